// File: rtl/float_adder_e4m3.sv
// rtl/float_adder_e4m3.sv - multi-cycle FP8 E4M3 adder; define E4M3_SAT_EN for saturating overflow
module float_adder_e4m3 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       is_output_valid
);

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS  = 7;
  // Largest exponent field; mantissa all-ones there is NaN, not a number
  localparam logic [EXP_W:0] EXP_MAX = (EXP_W + 1)'(2 * BIAS + 1);

  typedef enum logic [2:0] {LOAD, ALIGN, ADD, NORM, DONE} state_t;

  state_t state, state_next;

  // Operand X always holds the larger magnitude so the subtraction never goes negative
  logic             sx, sy;
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W:0]   mx, my;
  logic             nan_r;
  logic [6:0]       mx_al, my_al;   // {hidden, mantissa, guard, round, sticky}
  logic [7:0]       sum;            // carry bit on top

  // Unpack helpers: subnormals use effective exponent 1 and hidden bit 0
  logic             swap;
  logic [EXP_W-1:0] ea_eff, eb_eff;
  logic [MAN_W:0]   ma, mb;

  // LOAD-stage unpack and magnitude compare (bit pattern order equals magnitude order)
  always_comb begin
    swap   = b[6:0] > a[6:0];
    ea_eff = (a[6:3] == '0) ? 4'd1 : a[6:3];
    eb_eff = (b[6:3] == '0) ? 4'd1 : b[6:3];
    ma     = {a[6:3] != '0, a[2:0]};
    mb     = {b[6:3] != '0, b[2:0]};
  end

  logic [EXP_W-1:0] diff;
  logic [13:0]      wide;
  logic [6:0]       aligned;

  // ALIGN-stage shifter: bits falling off the bottom are folded into the sticky bit
  always_comb begin
    diff = ex - ey;
    wide = {my, 3'b000, 7'b0000000} >> diff;
    if (diff >= 4'd7) aligned = {6'b000000, |my};
    else              aligned = {wide[13:8], wide[7] | (|wide[6:0])};
  end

  logic [6:0]       nrm;
  logic [EXP_W:0]   e_n, ef;
  logic             rnd, ovf;
  logic [MAN_W+1:0] mant5;
  logic [MAN_W-1:0] frac;
  logic [7:0]       y_next;

  // NORM-stage normalise, round-to-nearest-even, and special-case selection
  always_comb begin
    if (sum[7]) begin
      nrm = {sum[7:2], |sum[1:0]};
      e_n = {1'b0, ex} + 5'd1;
    end else begin
      nrm = sum[6:0];
      e_n = {1'b0, ex};
    end
    // Left shift stops at exponent 1, which leaves a subnormal result
    for (int i = 0; i < 6; i++) begin
      if (!nrm[6] && e_n > 5'd1) begin
        nrm = nrm << 1;
        e_n = e_n - 5'd1;
      end
    end
    rnd   = nrm[2] & (nrm[3] | nrm[1] | nrm[0]);
    mant5 = {1'b0, nrm[6:3]} + {4'b0000, rnd};
    if (mant5[4]) begin
      ef   = e_n + 5'd1;
      frac = '0;
    end else begin
      ef   = mant5[3] ? e_n : 5'd0;
      frac = mant5[2:0];
    end
    ovf = (ef > EXP_MAX) || (ef == EXP_MAX && frac == 3'b111);
    if (nan_r)          y_next = 8'h7F;
    else if (sum == '0) y_next = {sx & sy, 7'h00};
    else if (ovf) begin
`ifdef E4M3_SAT_EN
      y_next = {sx, 7'h7E};
`else
      y_next = 8'h7F;
`endif
    end else            y_next = {sx, ef[3:0], frac};
  end

  // Next-state: one stage per clock, DONE holds until reset
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    state_next = ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = NORM;
      NORM:    state_next = DONE;
      default: state_next = DONE;
    endcase
  end

  // State, pipeline registers and registered result
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= LOAD;
      y               <= 8'h00;
      is_output_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        LOAD: begin
          sx    <= swap ? b[7] : a[7];
          sy    <= swap ? a[7] : b[7];
          ex    <= swap ? eb_eff : ea_eff;
          ey    <= swap ? ea_eff : eb_eff;
          mx    <= swap ? mb : ma;
          my    <= swap ? ma : mb;
          nan_r <= (&a[6:0]) | (&b[6:0]);
        end
        ALIGN: begin
          mx_al <= {mx, 3'b000};
          my_al <= aligned;
        end
        ADD: begin
          if (sx == sy) sum <= {1'b0, mx_al} + {1'b0, my_al};
          else          sum <= {1'b0, mx_al} - {1'b0, my_al};
        end
        NORM: begin
          y               <= y_next;
          is_output_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_float_adder_e4m3.sv
// tb/tb_float_adder_e4m3.sv - self-checking bench for float_adder_e4m3 (honours E4M3_SAT_EN)
module tb_float_adder_e4m3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [7:0] y;
  logic       is_output_valid;

  int checks = 0;
  int errors = 0;

  float_adder_e4m3 dut (
    .clock(clock),
    .reset(reset),
    .a(a),
    .b(b),
    .y(y),
    .is_output_valid(is_output_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

`ifdef E4M3_SAT_EN
  localparam logic [7:0] OVF_POS = 8'h7E;
  localparam logic [7:0] OVF_NEG = 8'hFE;
`else
  localparam logic [7:0] OVF_POS = 8'h7F;
  localparam logic [7:0] OVF_NEG = 8'h7F;
`endif

  // Magnitude of a code in units of 2^-9 (the smallest subnormal)
  function automatic int mag_of(input logic [6:0] c);
    int e, f;
    e = int'(c[6:3]);
    f = int'(c[2:0]);
    if (e == 0) return f;
    return (8 + f) << (e - 1);
  endfunction

  // Reference: exact integer sum, then nearest representable code, ties to even
  function automatic logic [7:0] ref_add(input logic [7:0] ra, input logic [7:0] rb);
    int va, vb, s, m, best, bestd, d;
    logic [6:0] c;
    if (ra[6:0] == 7'h7F || rb[6:0] == 7'h7F) return 8'h7F;
    va = ra[7] ? -mag_of(ra[6:0]) : mag_of(ra[6:0]);
    vb = rb[7] ? -mag_of(rb[6:0]) : mag_of(rb[6:0]);
    s  = va + vb;
    if (s == 0) return (ra[7] && rb[7]) ? 8'h80 : 8'h00;
    m = (s < 0) ? -s : s;
    // 464 is the midpoint between 448 and 480; ties go to 448 (even)
    if (m > 464 * 512) return (s < 0) ? OVF_NEG : OVF_POS;
    best  = 0;
    bestd = 1 << 30;
    for (int k = 0; k < 127; k++) begin
      c = 7'(k);
      d = mag_of(c) - m;
      if (d < 0) d = -d;
      if (d < bestd || (d == bestd && c[0] == 1'b0)) begin
        bestd = d;
        best  = k;
      end
    end
    return {s < 0, 7'(best)};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full operation: reset, release, check latency, result and hold
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_op, input logic [7:0] exp);
    string tag;
    tag = $sformatf("%h+%h", ta, tb_op);
    @(negedge clock);
    reset = 1'b1;
    a = ta;
    b = tb_op;
    @(negedge clock);
    chk({"reset ", tag}, {is_output_valid, y}, 9'h000);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk({"early_valid ", tag}, {8'h00, is_output_valid}, 9'h000);
    @(negedge clock);
    chk({"result ", tag}, {is_output_valid, y}, {1'b1, exp});
    a = ~ta;
    b = ~tb_op;
    repeat (2) @(negedge clock);
    chk({"hold ", tag}, {is_output_valid, y}, {1'b1, exp});
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{8'h40, 8'h40, 8'h48};
    vecs[1]  = '{8'h28, 8'h10, 8'h29};
    vecs[2]  = '{8'h50, 8'h10, 8'h50};
    vecs[3]  = '{8'h40, 8'hC0, 8'h00};
    vecs[4]  = '{8'h48, 8'hC0, 8'h40};
    vecs[5]  = '{8'h01, 8'h01, 8'h02};
    vecs[6]  = '{8'h7E, 8'h7E, OVF_POS};
    vecs[7]  = '{8'h7F, 8'h40, 8'h7F};
    vecs[8]  = '{8'h80, 8'h80, 8'h80};
    vecs[9]  = '{8'h00, 8'h80, 8'h00};
    vecs[10] = '{8'hFE, 8'hFE, OVF_NEG};
    vecs[11] = '{8'h7E, 8'h40, 8'h7E};
    vecs[12] = '{8'h38, 8'hB8, 8'h00};

    for (int i = 0; i < 13; i++) do_op(vecs[i].a, vecs[i].b, vecs[i].y);

    // Abort after LOAD and ALIGN edges, then restart with new operands
    @(negedge clock);
    reset = 1'b1;
    a = 8'h40;
    b = 8'h40;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_mid", {is_output_valid, y}, 9'h000);
    a = 8'h28;
    b = 8'h10;
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("restart_after_abort", {is_output_valid, y}, 9'h129);

    // Reset arriving on the NORM edge must win over the result
    @(negedge clock);
    reset = 1'b1;
    a = 8'h40;
    b = 8'h40;
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_at_norm", {is_output_valid, y}, 9'h000);

    for (int i = 0; i < 250; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, ref_add(ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
